cipher_in_packer: RTL and testbench
===================================

// Module: cipher_in_packer
// PURPOSE
//  Upstream load stage for the 128-bit block-cipher core.
//  - Accepts 32-bit Avalon-MM slave writes and assembles them into a {key,text} block of 2x128 bits.
//  - Buffers committed blocks in a DEPTH-entry FIFO.
//  - Presents blocks to the core over a valid/ready handshake, so software can queue work while the core runs.
// PARAMETERS
//  DEPTH  2  FIFO entries (power of 2, >=2); each entry is 256 bits {key,text}
// PORTS
//  clk        in   1    single clock, all logic rising-edge
//  reset      in   1    asynchronous, active-low reset (assert 0 clears immediately)
//  address    in   2    0=data word, 1=commit/control, 2=status (read)
//  write      in   1    Avalon write strobe
//  writedata  in   32   write data
//  read       in   1    Avalon read strobe
//  readdata   out  32   read data, registered
//  waitrequest out 1    Avalon stall
//  blk_valid  out  1    FIFO head holds a block
//  blk_ready  in   1    core accepts head block
//  blk_text   out  128  head plaintext
//  blk_key    out  128  head key
// BEHAVIOUR
//  Reset: waitrequest=0, readdata=0, blk_valid=0, blk_text/blk_key=0, wr_cnt=0, FIFO empty, err/ovf flags=0, last_key=0.
//  Data write (address 0, accepted when waitrequest=0):
//  - Word i = wr_cnt, 0..7.
//  - i=0..3 -> text[32*i +: 32], LSW first. i=4..7 -> key[32*(i-4) +: 32].
//  - wr_cnt increments by 1 per accepted write and saturates at 8.
//  - A 9th+ data write is dropped and sets sticky ovf.
//  FSM, advances on the clock edge of each accepted write:
//  - LD_TEXT (wr_cnt<4) -> LD_KEY (wr_cnt 4..7) -> ARMED (wr_cnt=8) -> STALL.
//  - Commit write: address 1, writedata[0]=0.
//    - In ARMED with FIFO not full: push {key,text}, last_key<=key, wr_cnt<=0, state LD_TEXT. Single cycle, waitrequest stays 0.
//    - In ARMED with FIFO full: state STALL, waitrequest=1 combinationally while STALL persists.
//    - STALL exit: the cycle a pop occurs (blk_valid&&blk_ready), the push happens on the same edge, waitrequest drops, state LD_TEXT.
//    - In LD_TEXT/LD_KEY (block incomplete): no push, sticky err<=1, wr_cnt<=0, state LD_TEXT.
//  Abort write (address 1, writedata[0]=1):
//  - wr_cnt<=0, state LD_TEXT. Clears err and ovf when writedata[1]=1.
//  - Never pushes; honoured in every state except STALL, which cannot accept writes.
//  Status read (address 2):
//  - waitrequest=1 on the first read cycle, 0 on the second with readdata valid.
//  - readdata = {16'b0, fifo_count[7:0], ovf, err, full, empty, wr_cnt[3:0]}.
//  - Reads of address 0/1 return 0.
//  FIFO and output handshake:
//  - blk_valid = !empty.
//  - blk_text/blk_key show the head entry combinationally from storage; they hold when blk_ready=0.
//  - Pop on the edge where blk_valid&&blk_ready.
//  - Push and pop on the same edge: both happen, count unchanged; allowed when full because the pop frees the slot.
//  - Pop with empty is ignored. Pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  Latency: commit edge -> blk_valid=1 on the next cycle when the FIFO was empty.
//  Reset mid-load or mid-stall: all state lost, FIFO flushed, waitrequest deasserts asynchronously.
// CONFIGURATION
//  KEY_REUSE_EN defined:
//  - Commit in LD_KEY with wr_cnt==4 (text only) is legal.
//  - It pushes {last_key,text} with no err and follows the same full/STALL rules.
//  - last_key=0 after reset.
//  KEY_REUSE_EN undefined: that commit is an incomplete block (err=1, no push); last_key register omitted.
// TESTING
//  1. Release reset; write text words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF, key 0x0..0x3 (LSW first); commit.
//     -> next cycle blk_valid=1, blk_text=0xCCDDEEFF8899AABB4455667700112233, blk_key=0x00000003000000020000000100000000.
//     Pulse blk_ready -> blk_valid=0.
//  2. blk_ready=0; commit DEPTH full blocks, then load and commit one more.
//     -> waitrequest=1 held; status full=1.
//     Pulse blk_ready one cycle -> waitrequest=0 that cycle, fifo_count stays DEPTH, head = block 2.
//  3. Five data writes, then commit -> no push, status err=1, wr_cnt=0; abort with writedata=0x3 -> err=0.
//  4. Nine data writes -> status ovf=1, wr_cnt=8; commit pushes the first 8 words only.
//  5. Mid-load (3 words) and during STALL, drive reset=0 between clock edges.
//     -> waitrequest=0, blk_valid=0, status reads 0x0000_0010 after release.
//  6. KEY_REUSE_EN: full block with key K, then 4 text words + commit.
//     -> second head blk_key=K, err=0; without the macro err=1 and no push.

Source files
------------

// File: rtl/cipher_in_packer_if.sv
// cipher_in_packer_if: Avalon-MM slave port plus the valid/ready block handshake toward the cipher core.
interface cipher_in_packer_if;
    logic [1:0]   address;
    logic         write;
    logic [31:0]  writedata;
    logic         read;
    logic [31:0]  readdata;
    logic         waitrequest;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_text;
    logic [127:0] blk_key;
    modport master (output address, write, writedata, read, blk_ready,
                    input readdata, waitrequest, blk_valid, blk_text, blk_key);
    modport slave (input address, write, writedata, read, blk_ready,
                   output readdata, waitrequest, blk_valid, blk_text, blk_key);
endinterface

// File: rtl/cipher_in_packer.sv
// cipher_in_packer: packs 32-bit Avalon writes into {key,text} blocks and queues them in a DEPTH-entry FIFO.
// Optional KEY_REUSE_EN: a text-only commit reuses the key of the last pushed block.
module cipher_in_packer #(
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic reset,
    cipher_in_packer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {LD_TEXT, LD_KEY, ARMED, STALL} state_t;
    state_t state, state_nx;
    logic [3:0] wr_cnt, wr_cnt_nx;
    logic [127:0] text, key, push_key;
    logic err, ovf, rd_phase, wait_c;
    logic [255:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic full, empty, pop, push, wr_acc, data_wr, ctl_wr, abort, commit, reuse, commit_ok;
    logic [31:0] status;
    logic unused;
    assign unused = ^bus.writedata[31:2];
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign pop = !empty && bus.blk_ready;
    assign wait_c = (state == STALL && !pop) || (bus.read && !rd_phase);
    assign wr_acc = bus.write && !wait_c;
    assign data_wr = wr_acc && bus.address == 2'd0 && state != STALL;
    assign ctl_wr = wr_acc && bus.address == 2'd1 && state != STALL;
    assign abort = ctl_wr && bus.writedata[0];
    assign commit = ctl_wr && !bus.writedata[0];
    assign commit_ok = state == ARMED || reuse;
    assign status = {16'b0, 8'(count), ovf, err, full, empty, wr_cnt};
    assign bus.waitrequest = wait_c;
    assign bus.blk_valid = !empty;
    assign bus.blk_text = empty ? '0 : mem[rptr][127:0];
    assign bus.blk_key = empty ? '0 : mem[rptr][255:128];
`ifdef KEY_REUSE_EN
    logic [127:0] last_key;
    assign reuse = commit && state == LD_KEY && wr_cnt == 4'd4;
    assign push_key = reuse ? last_key : key;
    always_ff @(posedge clk or negedge reset)
        if (!reset) last_key <= '0;
        else if (push) last_key <= push_key;
`else
    assign reuse = 1'b0;
    assign push_key = key;
`endif
    always_comb begin
        state_nx = state;
        wr_cnt_nx = wr_cnt;
        push = 1'b0;
        if (state == STALL) begin
            push = pop;
            state_nx = pop ? LD_TEXT : STALL;
            wr_cnt_nx = pop ? 4'd0 : wr_cnt;
        end else if (abort) begin
            state_nx = LD_TEXT;
            wr_cnt_nx = 4'd0;
        end else if (commit) begin
            push = commit_ok && (!full || pop);
            state_nx = (commit_ok && !push) ? STALL : LD_TEXT;
            wr_cnt_nx = (commit_ok && !push) ? wr_cnt : 4'd0;
        end else if (data_wr && !wr_cnt[3]) begin
            wr_cnt_nx = wr_cnt + 4'd1;
            state_nx = wr_cnt_nx[3] ? ARMED : wr_cnt_nx[2] ? LD_KEY : LD_TEXT;
        end
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= LD_TEXT;
            wr_cnt <= '0;
            text <= '0;
            key <= '0;
            err <= 1'b0;
            ovf <= 1'b0;
            rd_phase <= 1'b0;
            bus.readdata <= '0;
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            wr_cnt <= wr_cnt_nx;
            if (data_wr && wr_cnt[3:2] == 2'b00) text[{wr_cnt[1:0], 5'd0} +: 32] <= bus.writedata;
            if (data_wr && wr_cnt[3:2] == 2'b01) key[{wr_cnt[1:0], 5'd0} +: 32] <= bus.writedata;
            // a stalled text-only commit must later push the reused key
            if (reuse) key <= push_key;
            if (data_wr && wr_cnt[3]) ovf <= 1'b1;
            if (commit && !commit_ok) err <= 1'b1;
            if (abort && bus.writedata[1]) begin
                err <= 1'b0;
                ovf <= 1'b0;
            end
            rd_phase <= bus.read && !rd_phase;
            if (bus.read && !rd_phase) bus.readdata <= bus.address == 2'd2 ? status : '0;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wptr] <= {push_key, text};
endmodule

// File: tb/tb_cipher_in_packer.sv
// tb_cipher_in_packer: directed scoreboard bench for the cipher input packer (DEPTH=2).
module tb_cipher_in_packer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    logic [255:0] sb[$];
    logic [255:0] b1, b2, b3, b4, b5, b6, b7;
    cipher_in_packer_if bus();
    cipher_in_packer #(.DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [255:0] mkb(input int n);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = {8'(n), 8'(i), 16'h5A00 + 16'(i)};
        return b;
    endfunction
    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        int n = 0;
        bus.address = a;
        bus.writedata = d;
        bus.write = 1'b1;
        @(negedge clk);
        while (bus.waitrequest && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (bus.waitrequest) chk("write_timeout", bus.waitrequest, 0);
        step();
        bus.write = 1'b0;
    endtask
    task automatic status(input string tag, input logic [31:0] exp);
        int n = 0;
        logic [31:0] d;
        bus.address = 2'd2;
        bus.read = 1'b1;
        @(negedge clk);
        while (bus.waitrequest && n < 20) begin
            n++;
            @(negedge clk);
        end
        d = bus.readdata;
        step();
        bus.read = 1'b0;
        chk({tag, "_rdwait"}, n, 1);
        chk(tag, d, exp);
    endtask
    task automatic load(input logic [255:0] b, input int nw);
        for (int i = 0; i < nw; i++) av_write(2'd0, i < 8 ? b[32*i +: 32] : 32'hDEAD_BEEF);
    endtask
    task automatic take(input string tag);
        bus.blk_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid"}, bus.blk_valid, 1);
        if (sb.size() > 0) chk(tag, {bus.blk_key, bus.blk_text}, sb.pop_front());
        step();
        bus.blk_ready = 1'b0;
    endtask
    initial begin
        bus.address = '0;
        bus.write = 1'b0;
        bus.writedata = '0;
        bus.read = 1'b0;
        bus.blk_ready = 1'b0;
        b1 = {128'h00000003_00000002_00000001_00000000, 128'hCCDDEEFF_8899AABB_44556677_00112233};
        b2 = mkb(2);
        b3 = mkb(3);
        b4 = mkb(4);
        b5 = mkb(5);
        b6 = mkb(6);
        b7 = mkb(7);
        repeat (2) step();
        chk("rst_wait", bus.waitrequest, 0);
        chk("rst_valid", bus.blk_valid, 0);
        chk("rst_blk", {bus.blk_key, bus.blk_text}, 0);
        chk("rst_rdata", bus.readdata, 0);
        #3 reset = 1'b1;
        step();
        status("rst_status", 32'h10);
        // single block, one-cycle latency to the core
        load(b1, 8);
        chk("t1_pre_valid", bus.blk_valid, 0);
        av_write(2'd1, 32'h0);
        sb.push_back(b1);
        chk("t1_valid", bus.blk_valid, 1);
        chk("t1_head", {bus.blk_key, bus.blk_text}, b1);
        take("t1_pop");
        chk("t1_empty", bus.blk_valid, 0);
        // fill the FIFO, then stall a third commit until the core pops
        load(b2, 8);
        av_write(2'd1, 32'h0);
        sb.push_back(b2);
        load(b3, 8);
        av_write(2'd1, 32'h0);
        sb.push_back(b3);
        status("t2_full", 32'h220);
        load(b4, 8);
        status("t2_armed", 32'h228);
        bus.address = 2'd1;
        bus.writedata = 32'h0;
        bus.write = 1'b1;
        step();
        chk("t2_stall1", bus.waitrequest, 1);
        step();
        chk("t2_stall2", bus.waitrequest, 1);
        bus.blk_ready = 1'b1;
        @(negedge clk);
        chk("t2_release", bus.waitrequest, 0);
        chk("t2_pop_head", {bus.blk_key, bus.blk_text}, sb.pop_front());
        step();
        bus.write = 1'b0;
        bus.blk_ready = 1'b0;
        sb.push_back(b4);
        chk("t2_head", {bus.blk_key, bus.blk_text}, b3);
        status("t2_count", 32'h220);
        take("t2_pop_b");
        take("t2_pop_c");
        chk("t2_empty", bus.blk_valid, 0);
        // incomplete block commit, then abort clearing the flags
        load(b5, 5);
        av_write(2'd1, 32'h0);
        chk("t3_nopush", bus.blk_valid, 0);
        status("t3_err", 32'h50);
        av_write(2'd1, 32'h3);
        status("t3_clr", 32'h10);
        // overflowing ninth word is dropped
        load(b5, 9);
        status("t4_ovf", 32'h98);
        av_write(2'd1, 32'h0);
        sb.push_back(b5);
        take("t4_pop");
        status("t4_sticky", 32'h90);
        av_write(2'd1, 32'h3);
        status("t4_clr", 32'h10);
        // asynchronous reset mid-load with a queued block
        load(b6, 8);
        av_write(2'd1, 32'h0);
        load(b7, 3);
        #2 reset = 1'b0;
        #1;
        chk("t5_load_wait", bus.waitrequest, 0);
        chk("t5_load_valid", bus.blk_valid, 0);
        chk("t5_load_blk", {bus.blk_key, bus.blk_text}, 0);
        sb.delete();
        step();
        #3 reset = 1'b1;
        step();
        status("t5_load_status", 32'h10);
        // asynchronous reset during a stall
        load(b2, 8);
        av_write(2'd1, 32'h0);
        load(b3, 8);
        av_write(2'd1, 32'h0);
        load(b4, 8);
        bus.address = 2'd1;
        bus.writedata = 32'h0;
        bus.write = 1'b1;
        step();
        chk("t5_stall", bus.waitrequest, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_stall_wait", bus.waitrequest, 0);
        chk("t5_stall_valid", bus.blk_valid, 0);
        bus.write = 1'b0;
        step();
        #3 reset = 1'b1;
        step();
        status("t5_stall_status", 32'h10);
        // text-only commit after a full block with key K
        load(b6, 8);
        av_write(2'd1, 32'h0);
        sb.push_back(b6);
        take("t6_pop_k");
        load(b7, 4);
        av_write(2'd1, 32'h0);
`ifdef KEY_REUSE_EN
        sb.push_back({b6[255:128], b7[127:0]});
        status("t6_reuse_status", 32'h100);
        take("t6_reuse_pop");
`else
        chk("t6_nopush", bus.blk_valid, 0);
        status("t6_err", 32'h50);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
